// File: rtl/uart_tx_buf_if.sv
// uart_tx_buf_if: write-strobe and status bundle between the division
// controller (master) and the buffered UART transmitter (slave).
interface uart_tx_buf_if;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       busy;
   logic       full;
   logic       overflow;

   modport master (
      output tx_ready,
      output tx_data,
      input  busy,
      input  full,
      input  overflow
   );

   modport slave (
      input  tx_ready,
      input  tx_data,
      output busy,
      output full,
      output overflow
   );
endinterface : uart_tx_buf_if

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO feeding an 8N1 serialiser, LSB first, idle-high TX.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit (8E1 frames).
// The next frame is popped on the last stop-bit cycle, so queued bytes go
// out back to back with no idle gap.
module uart_tx_buf #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_buf_if.slave bus,
   output logic         txd
);
   localparam int unsigned BAUD_CNT = CLK_FREQ / BAUD;
   localparam int unsigned BCW      = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
   localparam int unsigned AW       = $clog2(FIFO_DEPTH);

   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_CNT - 1);
   localparam logic [AW:0]    DEPTH_C   = FIFO_DEPTH[AW:0];

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic [7:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic [2:0]     state_q, state_d;
   logic [BCW-1:0] baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           full_q, full_d;
   logic           overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
   logic           parity_q;
`endif

   logic baud_last;
   logic fifo_nonempty;
   logic pop;
   logic push_ok;

   assign baud_last     = (baud_q == BAUD_LAST);
   assign fifo_nonempty = (count_q != '0);
   // Pop from IDLE, or on the final stop-bit cycle to chain the next frame.
   assign pop     = fifo_nonempty &&
                    ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));
   // A full FIFO still accepts a write when a pop frees a slot this cycle.
   assign push_ok = bus.tx_ready && ((count_q != DEPTH_C) || pop);

   // FIFO pointer, occupancy and sticky overflow next-state.
   always_comb begin
      wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d     = (count_d == DEPTH_C);
      overflow_d = overflow_q | (bus.tx_ready & ~push_ok);
   end

   // Frame sequencer: baud counter clears on every state change.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               bit_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (pop) begin
                  shift_d = mem_q[rd_ptr_q];
                  bit_d   = '0;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            baud_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Line driver decoded from the registered state.
   always_comb begin
      case (state_q)
         S_START:  txd = 1'b0;
         S_DATA:   txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd = parity_q;
`endif
         default:  txd = 1'b1;
      endcase
   end

   // FIFO storage: contents need no reset, only the pointers do.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= bus.tx_data;
   end

`ifdef UART_TX_PARITY_EN
   // Even parity of the popped byte, kept while the shifter drains it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     parity_q <= 1'b0;
      else if (pop) parity_q <= ^mem_q[rd_ptr_q];
   end
`endif

   // State registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.busy     = (state_q != S_IDLE) || fifo_nonempty;
   assign bus.full     = full_q;
   assign bus.overflow = overflow_q;

endmodule : uart_tx_buf

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: table-driven frame checks plus a line-decoding scoreboard.
// Frame width follows UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_buf;
   localparam int BC = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * BC;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic txd;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   uart_tx_buf_if bus ();

   uart_tx_buf #(
      .CLK_FREQ   (100),
      .BAUD       (10),
      .FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .txd (txd)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;   // bit 0 = start bit, in line order
   } vec_t;

   logic [7:0] exp_q[$];
   int         starts[$];
   bit         mon_en = 1'b0;
   bit         mon_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Decodes frames off txd at bit centres and scores them against exp_q.
   initial begin : monitor
      int         cnt;
      logic [10:0] bits;
      cnt  = 0;
      bits = '0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            mon_busy = 1'b0;
         end else if (!mon_busy) begin
            if (txd == 1'b0) begin
               mon_busy = 1'b1;
               cnt      = 0;
               starts.push_back(cyc);
            end
         end else begin
            cnt++;
            if ((cnt % BC) == BC / 2) bits[cnt / BC] = txd;
            if (cnt == FL - 1) begin
               mon_busy = 1'b0;
               chk("frame_start", {31'd0, bits[0]}, 32'd0);
               chk("frame_stop", {31'd0, bits[NB-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
               chk("frame_parity", {31'd0, bits[9]}, {31'd0, ^bits[8:1]});
`endif
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL frame_unexpected actual=%0h expected=none", bits[8:1]);
               end else begin
                  chk("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   task automatic wait_idle(input int budget, output int t);
      int n;
      n = 0;
      while ((bus.busy || mon_busy || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle_within_budget", {31'd0, n < budget}, 32'd1);
      t = cyc;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t       vec[6];
      logic [7:0] bb[4];
      int         t;
      int         s0;
      int         bad;

`ifdef UART_TX_PARITY_EN
      vec[0] = '{8'h35, 11'b1_0_00110101_0};
      vec[1] = '{8'hA5, 11'b1_0_10100101_0};
      vec[2] = '{8'h00, 11'b1_0_00000000_0};
      vec[3] = '{8'hFF, 11'b1_0_11111111_0};
      vec[4] = '{8'h07, 11'b1_1_00000111_0};
      vec[5] = '{8'h03, 11'b1_0_00000011_0};
`else
      vec[0] = '{8'h35, 11'b1_00110101_0};
      vec[1] = '{8'hA5, 11'b1_10100101_0};
      vec[2] = '{8'h00, 11'b1_00000000_0};
      vec[3] = '{8'hFF, 11'b1_11111111_0};
      vec[4] = '{8'h07, 11'b1_00000111_0};
      vec[5] = '{8'h03, 11'b1_00000011_0};
`endif
      bb[0] = 8'hA5;
      bb[1] = 8'h0F;
      bb[2] = 8'hFF;
      bb[3] = 8'h00;

      bus.tx_ready = 1'b0;
      bus.tx_data  = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_full", {31'd0, bus.full}, 32'd0);
      chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
      rst    = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Single-byte frames from the vector table
      for (int v = 0; v < 6; v++) begin
         wait_idle(2 * FL, t);
         @(negedge clk);
         bus.tx_ready = 1'b1;
         bus.tx_data  = vec[v].data;
         exp_q.push_back(vec[v].data);
         @(negedge clk);
         bus.tx_ready = 1'b0;
         bus.tx_data  = 8'($urandom);
         chk("busy_rise", {31'd0, bus.busy}, 32'd1);
         chk("txd_before_start", {31'd0, txd}, 32'd1);
         @(negedge clk);
         chk("txd_start_edge", {31'd0, txd}, 32'd0);
         repeat (BC / 2) @(negedge clk);
         for (int b = 0; b < NB; b++) begin
            if (b > 0) repeat (BC) @(negedge clk);
            chk("frame_bit", {31'd0, txd}, {31'd0, vec[v].frame[b]});
         end
         repeat (BC / 2 - 1) @(negedge clk);
         chk("busy_last_cycle", {31'd0, bus.busy}, 32'd1);
         @(negedge clk);
         chk("busy_fall", {31'd0, bus.busy}, 32'd0);
      end

      // Back-to-back writes: four contiguous frames
      wait_idle(2 * FL, t);
      s0 = starts.size();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.tx_ready = 1'b1;
         bus.tx_data  = bb[i];
         exp_q.push_back(bb[i]);
      end
      @(negedge clk);
      bus.tx_ready = 1'b0;
      wait_idle(6 * FL, t);
      chk("b2b_frames", starts.size() - s0, 32'd4);
      if (starts.size() - s0 == 4) begin
         for (int i = 0; i < 3; i++)
            chk("b2b_gap", starts[s0+i+1] - starts[s0+i], FL);
         chk("b2b_total", t - starts[s0], 4 * FL);
      end

      // Overflow: six writes into an idle block, sixth is dropped
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            chk("ovf_full_before", {31'd0, bus.full}, 32'd1);
            chk("ovf_flag_before", {31'd0, bus.overflow}, 32'd0);
         end
         bus.tx_ready = 1'b1;
         bus.tx_data  = 8'h11 + 8'(i);
         if (i < 5) exp_q.push_back(8'h11 + 8'(i));
      end
      @(negedge clk);
      bus.tx_ready = 1'b0;
      chk("ovf_full", {31'd0, bus.full}, 32'd1);
      chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
      wait_idle(8 * FL, t);
      chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
      chk("ovf_full_drained", {31'd0, bus.full}, 32'd0);

      // Wrap-around: ten single writes, pointers cycle past depth
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.tx_ready = 1'b1;
         bus.tx_data  = 8'($urandom);
         exp_q.push_back(bus.tx_data);
         @(negedge clk);
         bus.tx_ready = 1'b0;
         wait_idle(2 * FL, t);
      end

      // Reset mid-frame with a full FIFO
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.tx_ready = 1'b1;
         bus.tx_data  = 8'h55;
      end
      @(negedge clk);
      bus.tx_ready = 1'b0;
      repeat (BC / 2) @(negedge clk);
      chk("pre_rst_txd", {31'd0, txd}, 32'd0);
      chk("pre_rst_full", {31'd0, bus.full}, 32'd1);
      mon_en = 1'b0;
      exp_q.delete();
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_txd", {31'd0, txd}, 32'd1);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_full", {31'd0, bus.full}, 32'd0);
      chk("midrst_overflow", {31'd0, bus.overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 3 * BC; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || bus.busy !== 1'b0) bad++;
      end
      chk("post_rst_quiet", bad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule : tb_uart_tx_buf

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered UART transmitter directly downstream of the division controller. It accepts result bytes as single-cycle write strobes, queues them in a small FIFO and serialises each one onto the TX pin as an 8N1 frame, LSB first. Bytes that arrive while a frame is on the wire are queued, not dropped. It drives the board TX pin and gives the controller busy/full status.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. `BAUD_CNT = CLK_FREQ/BAUD` is truncated and must be ≥ 2; the defaults give 5208 cycles per bit.
- `FIFO_DEPTH`, default 4: byte queue depth. Must be a power of two, ≥ 2.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset. One clock domain only.
- `tx_ready` in 1: write strobe. Each cycle it is high pushes `tx_data` once.
- `tx_data` in 8: byte to send. Sampled only when `tx_ready` is 1.
- `txd` out 1: serial line, idle high.
- `busy` out 1: 1 while a frame is in progress or the FIFO is non-empty.
- `full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `overflow` out 1: sticky. Set when a write is dropped; cleared only by reset.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers and a count 0..`FIFO_DEPTH`.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A write is accepted if count < `FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the write is dropped, `overflow` is set, and FIFO contents and pointers do not change.
  - Push and pop in the same cycle leave the count unchanged.
- **FSM states:** IDLE, START, DATA, (PARITY), STOP.
  - IDLE: `txd`=1. If count>0, pop the head byte into the shift register, load the bit counter to 0, go to START.
  - START: `txd`=0 for `BAUD_CNT` cycles, then go to DATA.
  - DATA: `txd`=shift[0]. Every `BAUD_CNT` cycles, shift right and increment the bit index. After bit 7 completes, go to PARITY if compiled in, otherwise STOP.
  - STOP: `txd`=1 for `BAUD_CNT` cycles. At the last cycle, if count>0, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- **Counters**
  - Baud counter: 0..`BAUD_CNT-1`, reset to 0 on every state change.
  - Bit index: 3 bits, wraps 7→0 on leaving DATA.
- `tx_data` is captured at the push edge. Later changes to it do not affect queued bytes.

## Timing
- **Reset values** (applied immediately when `rst` is asserted, including mid-frame):
  - `txd`=1, `busy`=0, `full`=0, `overflow`=0.
  - FIFO emptied, FSM in IDLE, all counters 0.
  - A partially sent frame is abandoned, not completed.
- **Latency:** with the block idle, a write at edge N makes `txd` fall at edge N+1.
- **Frame length:** 10·`BAUD_CNT` cycles (11·`BAUD_CNT` with parity). Every bit lasts exactly `BAUD_CNT` cycles.
- **Back-to-back frames:** the next start bit begins on the edge after the previous stop bit's last cycle.
- **Flags**
  - `busy` rises on the write edge and falls on the edge at which the FSM enters IDLE with the FIFO empty.
  - `full` and `overflow` are registered and update on the same edge as the write or pop that changes them.
- **Throughput:** holding `tx_ready` high for k cycles issues k writes. The upstream must strobe for one cycle per byte.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit, the XOR of the 8 data bits, for `BAUD_CNT` cycles.
  - Frame format is 8E1, 11 bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state. Frame format is 8N1, 10 bits.

## Test plan
All scenarios use `CLK_FREQ`=100 and `BAUD`=10, so `BAUD_CNT`=10.
- **Reset:** `rst`=0 during an active frame → `txd`=1, `busy`=0, `full`=0 and `overflow`=0 immediately. After release, `txd` stays 1 with no writes.
- **Single byte:** one write of 0x35 → `txd` low at the next edge. Sampling at bit centres (cycles 5, 15, …) gives 0,1,0,1,0,1,1,0,0,1. `busy` falls 100 cycles after `txd` first fell.
- **Back-to-back:** writes of 0xA5, 0x0F, 0xFF, 0x00 on consecutive cycles → four contiguous frames, 400 cycles total, no idle gap. Decoded bytes come out in write order.
- **Overflow:**
  - Write 6 bytes on consecutive cycles while idle. Byte 1 is popped at cycle 1, so bytes 2–5 fill the FIFO.
  - Result: byte 6 is dropped, `full`=1, `overflow`=1.
  - Only bytes 1–5 are transmitted. `overflow` stays 1 afterwards.
- **Wrap-around:** 10 bytes written one at a time, each after the previous frame finishes → all 10 received correctly, exercising pointer wrap.
- **Parity** (with `UART_TX_PARITY_EN`):
  - 0x07 → parity bit 1. 0x03 → parity bit 0.
  - Frame length is 110 cycles.
